// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver.
//   PS2_EXT / PS2_BRK : scan-code prefixes folded into key events
//   ps2_event_t       : one decoded key event {ext, brk, code}
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

endpackage

// File: rtl/ps2_kbd_rx_fifo.sv
// First-word-fall-through event FIFO for the PS/2 receiver.
//   clk, clrn  : clock, asynchronous active-low reset
//   push       : write push_data (dropped when full unless popped this cycle)
//   pop        : remove head entry (ignored when empty)
//   head       : current head entry, all-zero while empty
//   full/empty : occupancy status
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       push,
    input  ps2_event_t push_data,
    input  logic       pop,
    output ps2_event_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    // Extra pointer MSB tells a full FIFO (MSBs differ) from an empty one.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    ps2_event_t  mem [DEPTH];
    logic        pop_fire;
    logic        push_fire;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_fire  = pop && !empty;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign push_fire = push && (!full || pop_fire);
    assign head      = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + 1'b1;
            if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers define which
    // entries are meaningful and the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push_fire) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, shifts and checks
// 11-bit frames, folds E0/F0 prefixes into key events and queues them.
//   clk, clrn            : clock, asynchronous active-low reset
//   ps2_clk, ps2_data    : raw asynchronous PS/2 lines
//   clr_err              : pulse clearing the sticky flags
//   out_valid/out_ready  : FWFT event stream handshake
//   out_code/ext/brk     : head event fields
//   overflow, parity_err, timeout_err : sticky error flags
//   brk_cnt              : accepted release events, wraps mod 256
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       clr_err,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_code,
    output logic       out_ext,
    output logic       out_brk,
    output logic       overflow,
    output logic       parity_err,
    output logic       timeout_err,
    output logic [7:0] brk_cnt
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_last_q;
    logic                   strobe;
    logic                   bit_in;
    logic [3:0]             bit_cnt;
    logic [9:0]             shift_buf;
    logic [WD_W-1:0]        wd_cnt;
    logic                   ext_pend;
    logic                   brk_pend;
    logic                   frame_end;
    logic                   frame_good;
    logic                   frame_bad;
    logic                   timeout;
    logic [7:0]             rx_byte;
    logic                   push;
    logic                   pop_fire;
    logic                   push_ok;
    logic                   push_drop;
    logic                   fifo_full;
    logic                   fifo_empty;
    ps2_event_t             push_ev;
    ps2_event_t             head;

    // Synchronisers idle high, matching the released PS/2 lines.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync   <= '1;
            data_sync  <= '1;
            clk_last_q <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync  <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_last_q <= clk_sync[SYNC_STAGES-1];
        end
    end

    // Falling edge seen at the last stage: it read 1 last cycle, 0 now.
    assign strobe     = clk_last_q && !clk_sync[SYNC_STAGES-1];
    assign bit_in     = data_sync[SYNC_STAGES-1];
    assign frame_end  = strobe && (bit_cnt == 4'd10);
    assign rx_byte    = shift_buf[8:1];
    assign frame_good = frame_end && !shift_buf[0] && bit_in && (^shift_buf[9:1]);
    assign frame_bad  = frame_end && !frame_good;
    assign timeout    = (bit_cnt != 4'd0) && !strobe && (wd_cnt == WD_W'(TIMEOUT_CYC));

    // Bits enter at the MSB so that after ten strobes the start bit sits in
    // shift_buf[0] and the parity bit in shift_buf[9].
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_cnt   <= '0;
            shift_buf <= '0;
            wd_cnt    <= '0;
        end else if (timeout) begin
            bit_cnt <= '0;
            wd_cnt  <= '0;
        end else if (strobe) begin
            wd_cnt <= '0;
            if (bit_cnt == 4'd10) begin
                bit_cnt <= '0;
            end else begin
                shift_buf <= {bit_in, shift_buf[9:1]};
                bit_cnt   <= bit_cnt + 4'd1;
            end
        end else if (bit_cnt != 4'd0) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Prefix decoder: bad frames leave the pending flags untouched.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (timeout) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (frame_good) begin
            if (rx_byte == PS2_EXT) begin
                ext_pend <= 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk_pend <= 1'b1;
            end else begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

    assign push      = frame_good && (rx_byte != PS2_EXT) && (rx_byte != PS2_BRK);
    assign push_ev   = '{ext: ext_pend, brk: brk_pend, code: rx_byte};
    assign pop_fire  = out_ready && !fifo_empty;
    assign push_ok   = push && (!fifo_full || pop_fire);
    assign push_drop = push && fifo_full && !pop_fire;

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .clrn      (clrn),
        .push      (push),
        .push_data (push_ev),
        .pop       (out_ready),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Sticky flags: a set in the same cycle as clr_err wins.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            overflow    <= 1'b0;
            parity_err  <= 1'b0;
            timeout_err <= 1'b0;
            brk_cnt     <= '0;
        end else begin
            if (push_drop)      overflow <= 1'b1;
            else if (clr_err)   overflow <= 1'b0;
            if (frame_bad)      parity_err <= 1'b1;
            else if (clr_err)   parity_err <= 1'b0;
            if (timeout)        timeout_err <= 1'b1;
            else if (clr_err)   timeout_err <= 1'b0;
            if (push_ok && push_ev.brk) brk_cnt <= brk_cnt + 8'd1;
        end
    end

    assign out_valid = !fifo_empty;
    assign out_code  = head.code;
    assign out_ext   = head.ext;
    assign out_brk   = head.brk;

endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

Parametrised PS/2 keyboard receiver with a scan-code decoder and an event FIFO with a valid/ready interface. It samples the PS/2 clock/data lines and checks start, stop and odd-parity bits. It folds the E0 (extended) and F0 (break) prefixes into single key events and buffers those events in a configurable-depth FIFO. It sits between the board PS/2 pins and the keyboard consumer (display, MMIO keyboard register).

## Interface
- FIFO_DEPTH, 8: event FIFO entries; power of two, ≥2.
- SYNC_STAGES, 3: synchroniser flops on ps2_clk/ps2_data; ≥2.
- TIMEOUT_CYC, 50000: clk cycles without a ps2_clk falling edge before a partial frame is discarded; ≥16.
- clk  in  1  system clock; all logic on its rising edge.
- clrn  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock line, asynchronous.
- ps2_data  in  1  raw PS/2 data line, asynchronous.
- clr_err  in  1  single-cycle pulse that clears the sticky flags.
- out_valid  out  1  FIFO non-empty; head event presented.
- out_ready  in  1  consumer accepts the head event when out_valid & out_ready.
- out_code  out  8  scan code of the head event.
- out_ext  out  1  head event was E0-prefixed.
- out_brk  out  1  head event was F0-prefixed (key release).
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- parity_err  out  1  sticky: a frame failed start, stop or parity.
- timeout_err  out  1  sticky: a partial frame was discarded by the watchdog.
- brk_cnt  out  8  count of accepted release events; wraps mod 256.

## Operation
- Synchroniser: SYNC_STAGES flops per line. The sample strobe is a one-cycle pulse when the last two ps2_clk stages read 1 then 0. Data is taken from the last ps2_data stage in the same cycle.
- Frame: bit counter 0..10. Bits 0–9 go into the shift buffer. At bit 10 the frame is checked:
  - buffer[0]==0 (start);
  - the sampled bit==1 (stop);
  - XOR of buffer[9:1]==1 (odd parity).
  - The counter returns to 0 whether the check passes or fails.
- On a bad frame: set parity_err. The byte is discarded and the prefix flags are left unchanged.
- Decoder on a good byte:
  - E0 sets the pending ext flag.
  - F0 sets the pending brk flag.
  - Any other byte pushes {ext, brk, code} into the FIFO and clears both pending flags.
  - Prefixes never produce events.
- Watchdog: a counter runs while the bit counter is nonzero and reloads on every strobe. When it reaches TIMEOUT_CYC it resets the bit counter and the pending flags, and sets timeout_err.
- FIFO: first-word-fall-through. The out_* fields show the head entry whenever out_valid=1; they hold their value while out_ready=0.
- Push when full without a same-cycle pop: the new event is dropped and overflow is set. Push when full with a same-cycle pop: both happen and no overflow is flagged. Pop when empty: ignored.
- Read and write pointers are log2(FIFO_DEPTH)+1 bits wide; the MSB distinguishes full from empty.
- brk_cnt increments on each accepted push with brk=1, not on pops.
- Sticky flags: set has priority over clr_err in the same cycle.
- Reset values: out_valid=0, overflow=0, parity_err=0, timeout_err=0, brk_cnt=0, out_code/out_ext/out_brk=0. Reset also clears the pointers, bit counter, watchdog, pending flags and synchronisers (to 1, the idle line level).
- Reset mid-frame: the partial frame and all queued events are lost, with no error flagged.

## Timing
- Latency from the ps2_clk falling edge to the strobe: SYNC_STAGES clk cycles.
- Stop-bit strobe in cycle N with a non-prefix good byte: FIFO write at the end of N; out_valid=1 and out_code valid in cycle N+1.
- Pop at the end of the cycle in which out_valid & out_ready; the next entry (or out_valid=0) appears in the following cycle.
- Sticky flags rise in the cycle after the causing strobe or timeout; clr_err clears them in the cycle after the pulse.
- Throughput: at most one push per frame; one pop per clk cycle.

## Structure
- Package ps2_pkg:
  - localparams PS2_EXT=8'hE0 and PS2_BRK=8'hF0;
  - the event typedef {ext, brk, code[7:0]}, 10 bits.
- Sub-module ps2_event_fifo: parametrised FWFT FIFO with push/pop, full/empty outputs and the simultaneous push/pop-when-full rule.
- Top level: synchroniser, frame shifter and checker, watchdog, prefix decoder, brk_cnt.

## Test plan
- Frame 1C (A press), then F0 1C, with out_ready=1 → events {0,0,1C} then {0,1,1C}; brk_cnt=1; no error flags set.
- E0 F0 75 (release of extended up-arrow) → one event {1,1,75}; no event is emitted for E0 or F0.
- FIFO_DEPTH=4, out_ready=0, 5 frames 16,1E,26,25,2E → out_valid=1, head=16, overflow=1. Draining yields 16,1E,26,25; 2E is lost.
- Frame 29 with an even parity bit → parity_err=1, no event. Then frame 29 with correct parity → event {0,0,29}. clr_err → parity_err=0.
- 4 bits of a frame, then ps2_clk idle for TIMEOUT_CYC cycles → timeout_err=1. A following full frame 5A is received correctly.
- FIFO full with out_ready=1 while a new frame completes → pop and push in the same cycle, overflow stays 0, and the event count is preserved.
